melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_sequencer.sv | 118 +++++++++++
 tb/tb_melody_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a table of (note, duration) entries with a silent gap after each one.
// Outputs are registered copies of the next-state logic, so no input reaches an output combinationally.
module melody_sequencer #(
  parameter int CLK_HZ = 100000000,
  parameter int TICK_HZ = 1000,
  parameter int DEPTH = 16,
  parameter int GAP_TICKS = 20,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_note,
  input  logic [11:0]   wr_dur,
  output logic [3:0]    note_state,
  output logic          note_on,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] cur_idx
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, FIN} state_t;
  state_t state, state_n;
  logic [15:0] mem [DEPTH];
  logic [15:0] rd;
  logic [PW-1:0] pre, pre_n;
  logic [11:0] cnt, cnt_n;
  logic [AW-1:0] idx_n;
  logic [3:0] note_n;
  logic on_n, tick, eom, adv, end_loop;
  assign tick = pre == PW'(DIV - 1);
  assign end_loop = loop_en && cur_idx != '0;
  // The read address is the next index, so the entry is already in rd during LOAD.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= {wr_note, wr_dur};
    rd <= mem[idx_n];
  end
  always_comb begin
    state_n = state;
    idx_n = cur_idx;
    pre_n = (tick || (state != PLAY && state != GAP)) ? '0 : pre + PW'(1);
    cnt_n = cnt;
    note_n = note_state;
    on_n = 1'b0;
    eom = 1'b0;
    adv = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = LOAD;
        idx_n = '0;
      end
      LOAD: if (rd[11:0] == '0) eom = 1'b1;
      else begin
        state_n = PLAY;
        cnt_n = rd[11:0];
        note_n = rd[15:12];
        on_n = rd[15:12] != '0;
      end
      PLAY: begin
        on_n = note_state != '0;
        if (tick) begin
          cnt_n = cnt - 12'd1;
          if (cnt == 12'd1) begin
            on_n = 1'b0;
            state_n = GAP;
            cnt_n = 12'(GAP_TICKS);
            adv = GAP_TICKS == 0;
          end
        end
      end
      GAP: if (tick) begin
        cnt_n = cnt - 12'd1;
        adv = cnt == 12'd1;
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Stepping past the last entry is an end of melody, never a silent wrap.
    if (eom || (adv && cur_idx == AW'(DEPTH - 1))) begin
      state_n = end_loop ? LOAD : FIN;
      idx_n = end_loop ? '0 : cur_idx;
    end else if (adv) begin
      state_n = LOAD;
      idx_n = cur_idx + AW'(1);
    end
    if (stop) state_n = IDLE;
    if (state_n == IDLE || state_n == FIN) begin
      note_n = '0;
      on_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pre <= '0;
      cnt <= '0;
      cur_idx <= '0;
      note_state <= '0;
      note_on <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      pre <= pre_n;
      cnt <= cnt_n;
      cur_idx <= idx_n;
      note_state <= note_n;
      note_on <= on_n;
      busy <= state_n != IDLE;
      done <= state_n == FIN;
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed checks of playback timing, looping, stop, reset and table protection.
// Tick is 10 cycles and the gap is 2 ticks; the silent span between entries also includes the one-cycle LOAD.
module tb_melody_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_note = '0;
  logic [11:0] wr_dur = '0;
  logic [3:0] note_state;
  logic note_on, busy, done;
  logic [1:0] cur_idx;
  int checks = 0, failures = 0, done_cnt = 0;

  melody_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .DEPTH(4), .GAP_TICKS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_dur(wr_dur),
    .note_state(note_state), .note_on(note_on), .busy(busy), .done(done), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic write_entry(input logic [1:0] a, input logic [3:0] n, input logic [11:0] d);
    wr_addr = a; wr_note = n; wr_dur = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic lvl, output int n, output logic [3:0] ns);
    n = 0;
    ns = note_state;
    while (note_on === lvl && done !== 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({note_state, note_on, busy, done, cur_idx} !== 9'd0) begin
      failures++;
      $display("FAIL reset: outputs=%b required 0", {note_state, note_on, busy, done, cur_idx});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n, d0;
    logic [3:0] ns;
    write_entry(2'd0, 4'd1, 12'd3);
    write_entry(2'd1, 4'd5, 12'd2);
    write_entry(2'd2, 4'd7, 12'd0);
    write_entry(2'd3, 4'd0, 12'd0);
    d0 = done_cnt;
    pulse_start();
    run(1'b0, n, ns);
    checks++; if (n !== 1) begin failures++; $display("FAIL basic_load: got %0d cycles required 1", n); end
    run(1'b1, n, ns);
    checks++; if (n !== 30) begin failures++; $display("FAIL basic_on0: got %0d cycles required 30", n); end
    checks++; if (ns !== 4'd1) begin failures++; $display("FAIL basic_note0: got %0d required 1", ns); end
    run(1'b0, n, ns);
    checks++; if (n !== 21) begin failures++; $display("FAIL basic_gap0: got %0d cycles required 21", n); end
    run(1'b1, n, ns);
    checks++; if (n !== 20) begin failures++; $display("FAIL basic_on1: got %0d cycles required 20", n); end
    checks++; if (ns !== 4'd5) begin failures++; $display("FAIL basic_note1: got %0d required 5", ns); end
    run(1'b0, n, ns);
    checks++; if (n !== 21 || done !== 1'b1) begin failures++; $display("FAIL basic_end: got %0d cycles done=%b required 21 done=1", n, done); end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL basic_idle: busy=%b done=%b required 0 0", busy, done); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_loop_stop();
    int n, d0;
    logic [3:0] ns;
    loop_en = 1'b1;
    d0 = done_cnt;
    pulse_start();
    run(1'b0, n, ns);
    run(1'b1, n, ns);
    run(1'b0, n, ns);
    run(1'b1, n, ns);
    run(1'b0, n, ns);
    checks++; if (n !== 22 || done !== 1'b0) begin failures++; $display("FAIL loop_wrap_gap: got %0d cycles done=%b required 22 done=0", n, done); end
    checks++; if (note_state !== 4'd1 || note_on !== 1'b1) begin failures++; $display("FAIL loop_restart: note=%0d on=%b required 1 1", note_state, note_on); end
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++; if (note_on !== 1'b0 || busy !== 1'b0 || note_state !== 4'd0) begin failures++; $display("FAIL loop_stop: on=%b busy=%b note=%0d required 0 0 0", note_on, busy, note_state); end
    loop_en = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (done_cnt !== d0 || busy !== 1'b0) begin failures++; $display("FAIL loop_no_done: pulses=%0d busy=%b required 0 0", done_cnt - d0, busy); end
  endtask

  task automatic test_rest();
    int n, nz, bl, i0;
    write_entry(2'd0, 4'd0, 12'd4);
    write_entry(2'd1, 4'd3, 12'd0);
    pulse_start();
    n = 0; nz = 0; bl = 0; i0 = 0;
    while (done !== 1'b1 && n < 500) begin
      n++;
      if (note_on !== 1'b0 || note_state !== 4'd0) nz++;
      if (busy !== 1'b1) bl++;
      if (cur_idx === 2'd0) i0++;
      @(negedge clk);
    end
    checks++; if (n !== 62) begin failures++; $display("FAIL rest_len: got %0d cycles required 62", n); end
    checks++; if (i0 !== 61) begin failures++; $display("FAIL rest_entry_time: got %0d cycles required 61", i0); end
    checks++; if (nz !== 0 || bl !== 0) begin failures++; $display("FAIL rest_silent_busy: sounding=%0d idle=%0d required 0 0", nz, bl); end
    @(negedge clk);
  endtask

  task automatic test_full();
    int n, hi, d0;
    for (int i = 0; i < 4; i++) write_entry(2'(i), 4'(i + 1), 12'd1);
    d0 = done_cnt;
    pulse_start();
    n = 0; hi = 0;
    while (done !== 1'b1 && n < 500) begin
      n++;
      if (note_on === 1'b1) hi++;
      @(negedge clk);
    end
    checks++; if (n !== 124 || hi !== 40) begin failures++; $display("FAIL full_len: got %0d/%0d cycles required 124/40", n, hi); end
    checks++; if (cur_idx !== 2'd3) begin failures++; $display("FAIL full_idx: got %0d required 3", cur_idx); end
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (note_on !== 1'b0 || busy !== 1'b0) hi++;
    end
    checks++; if (hi !== 0 || done_cnt - d0 !== 1) begin failures++; $display("FAIL full_no_wrap: active=%0d pulses=%0d required 0 1", hi, done_cnt - d0); end
  endtask

  task automatic test_misc();
    int n;
    logic [3:0] ns;
    pulse_start();
    write_entry(2'd0, 4'd9, 12'd5);
    n = 0;
    while (busy === 1'b1 && n < 500) begin n++; @(negedge clk); end
    pulse_start();
    run(1'b0, n, ns);
    run(1'b1, n, ns);
    checks++; if (n !== 10 || ns !== 4'd1) begin failures++; $display("FAIL busy_write: got %0d cycles note %0d required 10 note 1", n, ns); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || note_on !== 1'b0) begin failures++; $display("FAIL start_stop: busy=%b on=%b required 0 0", busy, note_on); end
    pulse_start();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({note_state, note_on, busy, done, cur_idx} !== 9'd0) begin failures++; $display("FAIL async_reset: outputs=%b required 0", {note_state, note_on, busy, done, cur_idx}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_eom0();
    int n;
    write_entry(2'd0, 4'd2, 12'd0);
    loop_en = 1'b1;
    pulse_start();
    n = 1;
    while (done !== 1'b1 && n < 3) begin n++; @(negedge clk); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL eom0_done: done=%b after %0d cycles required 1", done, n); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL eom0_idle: busy=%b required 0", busy); end
    loop_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loop_stop();
    test_rest();
    test_full();
    test_misc();
    test_eom0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
